pulse_gen_multi: RTL and testbench



---
 rtl/pulse_gen_pkg.sv | 27 ++
 rtl/pulse_gen_chan.sv | 153 +++++++++++++++
 rtl/pulse_gen_multi.sv | 45 ++++
 tb/tb_pulse_gen_multi.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
// Optional feature macro: PULSE_GEN_RETRIGGER_EN (see pulse_gen_chan.sv).
package pulse_gen_pkg;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } pulse_state_t;

    // Widest counter the clamp helper below can handle
    localparam int MAX_CNT_W = 32;

    // A programmed width of zero would mean "no pulse", which is never
    // useful for a one-shot, so it is treated as the shortest legal pulse.
    function automatic logic [MAX_CNT_W-1:0] eff_width(input logic [MAX_CNT_W-1:0] width_cfg);
        logic [MAX_CNT_W-1:0] result;
        if (width_cfg == '0) begin
            result = {{(MAX_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            result = width_cfg;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse generator channel: level-to-pulse FSM, length counter,
// registered activity for edge detection and the sticky missed flag.
// Optional feature macro: PULSE_GEN_RETRIGGER_EN -- when defined, a new
// trigger edge during a pulse reloads the counter instead of being flagged.
module pulse_gen_chan
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_sig,
    input  logic             i_polarity,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_widthCfg,
    input  logic             i_clrMissed,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_missed
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pulse_state_t     r_state;
    pulse_state_t     w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic             r_actQ;
    logic             r_missed;
    logic             w_setMissed;
    logic             w_act;
    logic             w_edge;
    logic             w_pulse;
    logic [CNT_W-1:0] w_effWidth;
    logic [CNT_W-1:0] w_reload;

    // Polarity folds active-low inputs into a single active-high view
    assign w_act      = i_sig ^ i_polarity;
    assign w_edge     = w_act & ~r_actQ;
    assign w_effWidth = CNT_W'(eff_width(MAX_CNT_W'(i_widthCfg)));
    assign w_reload   = w_effWidth - ONE;

    // State and counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    // Registered activity, used only to find fresh edges during a pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_actQ <= 1'b0;
        end else begin
            r_actQ <= w_act;
        end
    end

    // Sticky missed flag: frozen while disabled, a set beats a clear
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_missed <= 1'b0;
        end else if (i_enable) begin
            if (w_setMissed) begin
                r_missed <= 1'b1;
            end else if (i_clrMissed) begin
                r_missed <= 1'b0;
            end
        end
    end

    // Next-state and counter logic; the trigger cycle itself is the first
    // pulse cycle, so the counter is loaded with W-1 remaining cycles
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_setMissed = 1'b0;
        if (!i_enable) begin
            w_nextState = IDLE;
            w_nextCount = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_act) begin
                        if (w_effWidth == ONE) begin
                            w_nextState = WAIT;
                            w_nextCount = '0;
                        end else begin
                            w_nextState = PULSE;
                            w_nextCount = w_reload;
                        end
                    end
                end
                PULSE: begin
`ifdef PULSE_GEN_RETRIGGER_EN
                    if (w_edge) begin
                        if (w_effWidth == ONE) begin
                            w_nextState = WAIT;
                            w_nextCount = '0;
                        end else begin
                            w_nextCount = w_reload;
                        end
                    end else if (r_count == ONE) begin
                        w_nextState = WAIT;
                        w_nextCount = '0;
                    end else begin
                        w_nextCount = r_count - ONE;
                    end
`else
                    w_setMissed = w_edge;
                    if (r_count == ONE) begin
                        w_nextState = WAIT;
                        w_nextCount = '0;
                    end else begin
                        w_nextCount = r_count - ONE;
                    end
`endif
                end
                WAIT: begin
                    if (!w_act) begin
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end
            endcase
        end
    end

    // Output decode: IDLE is Mealy so the pulse starts in the trigger cycle
    always_comb begin
        w_pulse = 1'b0;
        if (i_enable) begin
            case (r_state)
                IDLE:    w_pulse = w_act;
                PULSE:   w_pulse = 1'b1;
                default: w_pulse = 1'b0;
            endcase
        end
    end

    // Holding reset keeps the Mealy path quiet even with inputs active
    assign o_pulse  = w_pulse & reset_n;
    assign o_busy   = (r_state != IDLE);
    assign o_missed = r_missed;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel one-shot pulse generator: CHANNELS independent channels
// sharing one runtime pulse width.
// Optional feature macro: PULSE_GEN_RETRIGGER_EN (retrigger during a pulse).
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] sig,
    input  logic [CHANNELS-1:0] polarity,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CNT_W-1:0]    width_cfg,
    input  logic [CHANNELS-1:0] clr_missed,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] missed
);

    // The width clamp helper works on at most MAX_CNT_W bits
    if (CNT_W > MAX_CNT_W || CNT_W < 2) begin : g_badWidth
        $error("pulse_gen_multi: CNT_W out of range");
    end

    // One fully independent channel per bit; only width_cfg is shared
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        pulse_gen_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clock       (clock),
            .reset_n     (reset_n),
            .i_sig       (sig[ch]),
            .i_polarity  (polarity[ch]),
            .i_enable    (enable[ch]),
            .i_widthCfg  (width_cfg),
            .i_clrMissed (clr_missed[ch]),
            .o_pulse     (pulse[ch]),
            .o_busy      (busy[ch]),
            .o_missed    (missed[ch])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi (CHANNELS=4, CNT_W=8).
// Honours PULSE_GEN_RETRIGGER_EN when choosing expectations.
module tb_pulse_gen_multi;

    logic       clock;
    logic       reset_n;
    logic [3:0] sig;
    logic [3:0] polarity;
    logic [3:0] enable;
    logic [7:0] width_cfg;
    logic [3:0] clr_missed;
    logic [3:0] pulse;
    logic [3:0] busy;
    logic [3:0] missed;

    int vectors;
    int miscompares;

    pulse_gen_multi #(
        .CHANNELS (4),
        .CNT_W    (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sig        (sig),
        .polarity   (polarity),
        .enable     (enable),
        .width_cfg  (width_cfg),
        .clr_missed (clr_missed),
        .pulse      (pulse),
        .busy       (busy),
        .missed     (missed)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Start a new cycle: wait for the edge, then drive this cycle's inputs
    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] pol,
                                 input logic [3:0] en, input logic [7:0] w,
                                 input logic [3:0] clr);
        @(posedge clock);
        #1;
        sig        = s;
        polarity   = pol;
        enable     = en;
        width_cfg  = w;
        clr_missed = clr;
    endtask

    // Compare outputs mid-cycle, well away from the active edge
    task automatic checkOutput(input string tag, input logic [3:0] ePulse,
                               input logic [3:0] eBusy, input logic [3:0] eMissed);
        #2;
        vectors++;
        assert (pulse === ePulse) else begin
            miscompares++;
            $error("[TB] FAIL %s pulse: observed %b expected %b", tag, pulse, ePulse);
        end
        vectors++;
        assert (busy === eBusy) else begin
            miscompares++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, eBusy);
        end
        vectors++;
        assert (missed === eMissed) else begin
            miscompares++;
            $error("[TB] FAIL %s missed: observed %b expected %b", tag, missed, eMissed);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [3:0] pol, input logic [3:0] en,
                        input logic [7:0] w, input logic [3:0] clr,
                        input logic [3:0] ePulse, input logic [3:0] eBusy,
                        input logic [3:0] eMissed, input string tag);
        applyStimulus(s, pol, en, w, clr);
        checkOutput(tag, ePulse, eBusy, eMissed);
    endtask

    // Directed sequence with hand-computed expectations
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        sig         = 4'hF;
        polarity    = 4'h0;
        enable      = 4'hF;
        width_cfg   = 8'd1;
        clr_missed  = 4'h0;

        // Reset held two edges with every input active
        step(4'hF, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, "rst1");
        step(4'hF, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, "rst2");
        reset_n = 1'b1;
        checkOutput("release", 4'hF, 4'h0, 4'h0);
        step(4'hF, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'hF, 4'h0, "rel_wait");
        step(4'h0, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'hF, 4'h0, "rel_low");
        step(4'h0, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, "rel_idle");

        // Width 3 on ch0, input held high
        step(4'h1, 4'h0, 4'hF, 8'd3, 4'h0, 4'h1, 4'h0, 4'h0, "w3_c0");
        step(4'h1, 4'h0, 4'hF, 8'd3, 4'h0, 4'h1, 4'h1, 4'h0, "w3_c1");
        step(4'h1, 4'h0, 4'hF, 8'd3, 4'h0, 4'h1, 4'h1, 4'h0, "w3_c2");
        step(4'h1, 4'h0, 4'hF, 8'd3, 4'h0, 4'h0, 4'h1, 4'h0, "w3_hold");
        step(4'h0, 4'h0, 4'hF, 8'd3, 4'h0, 4'h0, 4'h1, 4'h0, "w3_low");
        step(4'h0, 4'h0, 4'hF, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0, "w3_idle");

        // Width 0 clamps to a single cycle
        step(4'h1, 4'h0, 4'hF, 8'd0, 4'h0, 4'h1, 4'h0, 4'h0, "w0_c0");
        step(4'h1, 4'h0, 4'hF, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0, "w0_hold");
        step(4'h0, 4'h0, 4'hF, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0, "w0_low");
        step(4'h0, 4'h0, 4'hF, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, "w0_idle");

        // Width 1
        step(4'h1, 4'h0, 4'hF, 8'd1, 4'h0, 4'h1, 4'h0, 4'h0, "w1_c0");
        step(4'h1, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h1, 4'h0, "w1_hold");
        step(4'h0, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h1, 4'h0, "w1_low");
        step(4'h0, 4'h0, 4'hF, 8'd1, 4'h0, 4'h0, 4'h0, 4'h0, "w1_idle");

        // Width 255: trigger cycle plus 254 counted cycles
        step(4'h1, 4'h0, 4'hF, 8'd255, 4'h0, 4'h1, 4'h0, 4'h0, "w255_c0");
        for (int i = 0; i < 254; i++) begin
            step(4'h1, 4'h0, 4'hF, 8'd255, 4'h0, 4'h1, 4'h1, 4'h0, "w255_hi");
        end
        step(4'h1, 4'h0, 4'hF, 8'd255, 4'h0, 4'h0, 4'h1, 4'h0, "w255_end");
        step(4'h0, 4'h0, 4'hF, 8'd255, 4'h0, 4'h0, 4'h1, 4'h0, "w255_low");
        step(4'h0, 4'h0, 4'hF, 8'd255, 4'h0, 4'h0, 4'h0, 4'h0, "w255_idle");

        // Active-low ch1: falling sig[1] triggers ch1 only
        step(4'h2, 4'h2, 4'hF, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, "pol_quiet");
        step(4'h0, 4'h2, 4'hF, 8'd2, 4'h0, 4'h2, 4'h0, 4'h0, "pol_c0");
        step(4'h0, 4'h2, 4'hF, 8'd2, 4'h0, 4'h2, 4'h2, 4'h0, "pol_c1");
        step(4'h0, 4'h2, 4'hF, 8'd2, 4'h0, 4'h0, 4'h2, 4'h0, "pol_hold");
        step(4'h2, 4'h2, 4'hF, 8'd2, 4'h0, 4'h0, 4'h2, 4'h0, "pol_inact");
        step(4'h2, 4'h2, 4'hF, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, "pol_idle");
        step(4'h0, 4'h0, 4'hF, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, "pol_restore");

        // Width change mid-pulse does not shorten it
        step(4'h1, 4'h0, 4'hF, 8'd5, 4'h0, 4'h1, 4'h0, 4'h0, "wchg_c0");
        step(4'h1, 4'h0, 4'hF, 8'd2, 4'h0, 4'h1, 4'h1, 4'h0, "wchg_c1");
        step(4'h1, 4'h0, 4'hF, 8'd2, 4'h0, 4'h1, 4'h1, 4'h0, "wchg_c2");
        step(4'h1, 4'h0, 4'hF, 8'd2, 4'h0, 4'h1, 4'h1, 4'h0, "wchg_c3");
        step(4'h1, 4'h0, 4'hF, 8'd2, 4'h0, 4'h1, 4'h1, 4'h0, "wchg_c4");
        step(4'h1, 4'h0, 4'hF, 8'd2, 4'h0, 4'h0, 4'h1, 4'h0, "wchg_end");
        step(4'h0, 4'h0, 4'hF, 8'd2, 4'h0, 4'h0, 4'h1, 4'h0, "wchg_low");
        step(4'h0, 4'h0, 4'hF, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, "wchg_idle");

        // Second edge during a width-6 pulse
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h0, 4'h0, "redge_c0");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c1");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c2");
`ifdef PULSE_GEN_RETRIGGER_EN
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c3");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c4");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c5");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c6");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h0, "redge_c7");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h1, 4'h0, "redge_low");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h0, 4'h0, "redge_idle");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h1, 4'h0, 4'h0, 4'h0, "redge_clr");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h0, 4'h0, "redge_clred");
`else
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h1, "redge_c3");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h1, "redge_c4");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h1, 4'h1, 4'h1, "redge_c5");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h1, 4'h1, "redge_c6");
        step(4'h1, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h1, 4'h1, "redge_c7");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h1, 4'h1, "redge_low");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h0, 4'h1, "redge_idle");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h1, 4'h0, 4'h0, 4'h1, "redge_clr");
        step(4'h0, 4'h0, 4'hF, 8'd6, 4'h0, 4'h0, 4'h0, 4'h0, "redge_clred");
`endif

        // Enable drop on ch2 during a 4-cycle pulse, then re-enable high
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h0, 4'h0, "en_c0");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h4, 4'h0, "en_c1");
        step(4'h4, 4'h0, 4'hB, 8'd4, 4'h0, 4'h0, 4'h4, 4'h0, "en_drop");
        step(4'h4, 4'h0, 4'hB, 8'd4, 4'h0, 4'h0, 4'h0, 4'h0, "en_off_idle");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h0, 4'h0, "en_re_c0");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h4, 4'h0, "en_re_c1");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h4, 4'h0, "en_re_c2");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h4, 4'h4, 4'h0, "en_re_c3");
        step(4'h4, 4'h0, 4'hF, 8'd4, 4'h0, 4'h0, 4'h4, 4'h0, "en_re_end");
        step(4'h0, 4'h0, 4'hF, 8'd4, 4'h0, 4'h0, 4'h4, 4'h0, "en_low");
        step(4'h0, 4'h0, 4'hF, 8'd4, 4'h0, 4'h0, 4'h0, 4'h0, "en_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
